// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses pll_rst, waits for synced lock with timeout/retry, holds sys_rst until lock is stable.
// Latency: pll_locked loss in RUN raises sys_rst within 3 refclk edges; no backpressure (free-running control block).
// Optional PLL_SUP_LOSS_CNT_EN adds the lost_cnt port counting RUN -> RESET_PLL lock losses.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int STABLE_CYC       = 1024,
    parameter int CNT_W            = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retry_cnt
`ifdef PLL_SUP_LOSS_CNT_EN
    ,
    output logic [CNT_W-1:0] lost_cnt
`endif
);

    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_ALL = (MAX_AB > STABLE_CYC) ? MAX_AB : STABLE_CYC;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYC - 1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       sync_q, sync_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
    logic             lock_s;
`ifdef PLL_SUP_LOSS_CNT_EN
    logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;
`endif

    // pll_locked is asynchronous; lock_s is the only place it enters the logic
    assign sync_d = {sync_q[0], pll_locked};
    assign lock_s = sync_q[1];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        timeout_err_d = timeout_err_q;
        retry_cnt_d   = retry_cnt_q;
`ifdef PLL_SUP_LOSS_CNT_EN
        lost_cnt_d    = lost_cnt_q;
`endif
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                // lock seen in the timeout cycle takes priority over the retry
                if (lock_s) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = RESET_PLL;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                    retry_cnt_d   = (retry_cnt_q == '1) ? retry_cnt_q : retry_cnt_q + 1'b1;
                end
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d     = RESET_PLL;
                    retry_cnt_d = (retry_cnt_q == '1) ? retry_cnt_q : retry_cnt_q + 1'b1;
`ifdef PLL_SUP_LOSS_CNT_EN
                    lost_cnt_d  = (lost_cnt_q == '1) ? lost_cnt_q : lost_cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q       <= RESET_PLL;
            cnt_q         <= '0;
            sync_q        <= '0;
            timeout_err_q <= 1'b0;
            retry_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync_q        <= sync_d;
            timeout_err_q <= timeout_err_d;
            retry_cnt_q   <= retry_cnt_d;
        end
    end

`ifdef PLL_SUP_LOSS_CNT_EN
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lost_cnt_q <= '0;
        end else begin
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign lost_cnt = lost_cnt_q;
`endif

    assign pll_rst     = (state_q == RESET_PLL);
    assign ready       = (state_q == RUN);
    assign sys_rst     = !ready;
    assign timeout_err = timeout_err_q;
    assign retry_cnt   = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: per-cycle expected outputs are queued with the stimulus and popped as the DUT runs.
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       timeout_err;
    logic [1:0] retry_cnt;
`ifdef PLL_SUP_LOSS_CNT_EN
    logic [1:0] lost_cnt;
`endif

    typedef struct packed {
        logic       pr;
        logic       sr;
        logic       rd;
        logic       te;
        logic [1:0] rc;
        logic [1:0] lc;
    } exp_t;

    exp_t exp_q[$];
    logic stim_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #10 refclk = ~refclk;

    pll_lock_supervisor #(
        .RST_PULSE_CYC   (4),
        .LOCK_TIMEOUT_CYC(20),
        .STABLE_CYC      (8),
        .CNT_W           (2)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .timeout_err(timeout_err),
        .retry_cnt  (retry_cnt)
`ifdef PLL_SUP_LOSS_CNT_EN
        ,
        .lost_cnt   (lost_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {26'd0, pll_rst, sys_rst, ready, timeout_err, retry_cnt};
    endfunction

    // queue n cycles of expected outputs {pll_rst, sys_rst, ready, timeout_err, retry_cnt, lost_cnt}
    task automatic px(input int n, input logic pr, input logic sr, input logic rd,
                      input logic te, input int rc, input int lc);
        exp_t e;
        e.pr = pr;
        e.sr = sr;
        e.rd = rd;
        e.te = te;
        e.rc = 2'(rc);
        e.lc = 2'(lc);
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic ps(input int n, input logic v);
        for (int i = 0; i < n; i++) stim_q.push_back(v);
    endtask

    // compare each queued cycle, then drive that cycle's pll_locked value into the next edge
    task automatic run_seg(input string tag);
        exp_t e;
        int   c;
        c = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            check_eq($sformatf("%s[%0d]", tag, c), obs_vec(),
                     {26'd0, e.pr, e.sr, e.rd, e.te, e.rc});
`ifdef PLL_SUP_LOSS_CNT_EN
            check_eq($sformatf("%s_lost[%0d]", tag, c), {30'd0, lost_cnt}, {30'd0, e.lc});
`endif
            if (stim_q.size() > 0) pll_locked = stim_q.pop_front();
            @(negedge refclk);
            c++;
        end
        stim_q.delete();
    endtask

    // asynchronous reset assertion is checked before any clock edge; release lands on a falling edge
    task automatic do_reset(input string tag, input logic lk);
        #2;
        pll_locked = lk;
        rst = 1'b1;
        #1;
        check_eq(tag, obs_vec(), {26'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
`ifdef PLL_SUP_LOSS_CNT_EN
        check_eq({tag, "_lost"}, {30'd0, lost_cnt}, 32'd0);
`endif
        @(negedge refclk);
        rst = 1'b0;
    endtask

    // clean start with lock held high: 4 cycles pll_rst, 1 WAIT_LOCK, 8 STABILIZE, then RUN
    task automatic boot_seq(input string tag, input int run_n);
        px(4, 1, 1, 0, 0, 0, 0);
        px(9, 0, 1, 0, 0, 0, 0);
        px(run_n, 0, 0, 1, 0, 0, 0);
        ps(13 + run_n, 1'b1);
        run_seg(tag);
    endtask

    // lock drops for 2 cycles while in RUN: sys_rst on the third cycle, PLL re-reset, relock to RUN
    task automatic loss_seq(input string tag, input int r, input int l);
        px(3, 0, 0, 1, 0, r, l);
        px(4, 1, 1, 0, 0, r + 1, l + 1);
        px(9, 0, 1, 0, 0, r + 1, l + 1);
        px(4, 0, 0, 1, 0, r + 1, l + 1);
        ps(2, 1'b0);
        ps(18, 1'b1);
        run_seg(tag);
    endtask

    initial begin
        @(negedge refclk);

        // power-up boot, then two lock losses in RUN
        do_reset("rst_init", 1'b1);
        boot_seq("boot", 5);
        loss_seq("loss1", 0, 0);
        loss_seq("loss2", 1, 1);

        // never locks: timeout every 24 cycles, retry_cnt saturates at 3, lost_cnt untouched
        do_reset("rst_after_run", 1'b0);
        px(4, 1, 1, 0, 0, 0, 0);
        px(20, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            px(4, 1, 1, 0, 1, (k > 3) ? 3 : k, 0);
            px(20, 0, 1, 0, 1, (k > 3) ? 3 : k, 0);
        end
        ps(120, 1'b0);
        run_seg("timeout");

        // 3-cycle lock glitch mid-STABILIZE: back to WAIT_LOCK without a PLL reset
        do_reset("rst_after_timeout", 1'b1);
        px(4, 1, 1, 0, 0, 0, 0);
        px(17, 0, 1, 0, 0, 0, 0);
        px(3, 0, 0, 1, 0, 0, 0);
        ps(7, 1'b1);
        ps(3, 1'b0);
        ps(14, 1'b1);
        run_seg("glitch");

        // reset during STABILIZE and during RESET_PLL, then a full clean restart
        do_reset("rst_pre_stab", 1'b1);
        px(4, 1, 1, 0, 0, 0, 0);
        px(4, 0, 1, 0, 0, 0, 0);
        ps(8, 1'b1);
        run_seg("to_stab");
        do_reset("rst_in_stab", 1'b1);
        px(2, 1, 1, 0, 0, 0, 0);
        ps(2, 1'b1);
        run_seg("to_rstpll");
        do_reset("rst_in_rstpll", 1'b1);
        boot_seq("reboot", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
